// File: rtl/temporizador_descendente_pkg.sv
// Shared definitions for the loadable down-counter/timer: bit-width helper
// and FSM state encoding.
package temporizador_descendente_pkg;

  // Number of bits needed to represent 'value' (same helper as the up-counter).
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned v;
    int unsigned bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    return bits;
  endfunction

  typedef enum logic {
    REPOSO = 1'b0,
    CUENTA = 1'b1
  } estado_t;

endpackage

// File: rtl/temporizador_descendente.sv
// Loadable down-counter/timer. A start command loads a (saturated) value,
// the count decrements once per enable tick and a one-cycle fin_cuenta pulse
// marks terminal count. Load value N yields terminal after N+1 enable ticks.
// Optional feature: define AUTORRECARGA_EN to reload on terminal and keep
// counting (periodic tick); otherwise the timer is one-shot.
module temporizador_descendente
  import temporizador_descendente_pkg::*;
#(
  parameter  int unsigned MODULO = 16,
  localparam int unsigned W      = clogb2(MODULO - 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         arranque,
  input  logic [W-1:0] valor_carga,
  input  logic         enable,
  input  logic         parar,
  output logic [W-1:0] cuenta,
  output logic         ocupado,
  output logic         fin_cuenta
);

  localparam logic [W-1:0] MAX_CUENTA = W'(MODULO - 1);

  estado_t      estado, estado_next;
  logic [W-1:0] cuenta_next;
  logic         fin_next;
  logic [W-1:0] carga_sat;

`ifdef AUTORRECARGA_EN
  logic [W-1:0] recarga, recarga_next;
`endif

  // Load value clipped to the largest supported count.
  always_comb begin
    carga_sat = (valor_carga > MAX_CUENTA) ? MAX_CUENTA : valor_carga;
  end

  // State, count and terminal pulse registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado     <= REPOSO;
      cuenta     <= '0;
      fin_cuenta <= 1'b0;
`ifdef AUTORRECARGA_EN
      recarga    <= '0;
`endif
    end else begin
      estado     <= estado_next;
      cuenta     <= cuenta_next;
      fin_cuenta <= fin_next;
`ifdef AUTORRECARGA_EN
      recarga    <= recarga_next;
`endif
    end
  end

  // Next-state logic: start, abort (highest priority in CUENTA), decrement, terminal.
  always_comb begin
    estado_next = estado;
    cuenta_next = cuenta;
    fin_next    = 1'b0;
`ifdef AUTORRECARGA_EN
    recarga_next = recarga;
`endif
    case (estado)
      REPOSO: begin
        if (arranque) begin
          cuenta_next = carga_sat;
`ifdef AUTORRECARGA_EN
          recarga_next = carga_sat;
`endif
          estado_next = CUENTA;
        end
      end
      CUENTA: begin
        if (parar) begin
          estado_next = REPOSO;
        end else if (enable) begin
          if (cuenta != '0) begin
            cuenta_next = cuenta - W'(1);
          end else begin
            fin_next = 1'b1;
`ifdef AUTORRECARGA_EN
            cuenta_next = recarga;
`else
            estado_next = REPOSO;
`endif
          end
        end
      end
      default: estado_next = REPOSO;
    endcase
  end

  // ocupado is a direct decode of the state register, so it is registered too.
  always_comb begin
    ocupado = (estado == CUENTA);
  end

endmodule

// File: tb/tb_temporizador_descendente.sv
// Scoreboard bench for temporizador_descendente. A reference model counts
// remaining ticks until terminal and pushes the expected outputs after every
// clock edge; an independent monitor pops and compares them.
// MODULO=12 is used so that load-value saturation is reachable with W=4.
module tb_temporizador_descendente;
  import temporizador_descendente_pkg::*;

  localparam int unsigned MODULO = 12;
  localparam int unsigned W      = clogb2(MODULO - 1);

  typedef struct packed {
    logic [W-1:0] cuenta;
    logic         ocupado;
    logic         fin_cuenta;
  } salida_t;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         arranque = 1'b0;
  logic [W-1:0] valor_carga = '0;
  logic         enable = 1'b0;
  logic         parar = 1'b0;
  logic [W-1:0] cuenta;
  logic         ocupado;
  logic         fin_cuenta;

  salida_t esperado_q[$];
  int total = 0;
  int bad   = 0;

  temporizador_descendente #(.MODULO(MODULO)) dut (
    .clock       (clock),
    .reset       (reset),
    .arranque    (arranque),
    .valor_carga (valor_carga),
    .enable      (enable),
    .parar       (parar),
    .cuenta      (cuenta),
    .ocupado     (ocupado),
    .fin_cuenta  (fin_cuenta)
  );

  always #5 clock = ~clock;

  // Reference model: 'restantes' = enable ticks still needed to reach terminal.
  int  restantes = 0;
  int  periodo   = 1;
  int  mostrada  = 0;
  bit  activo    = 0;
  bit  pulso     = 0;

  always @(posedge clock) begin
    salida_t e;
    pulso = 0;
    if (!reset) begin
      activo   = 0;
      mostrada = 0;
      restantes = 0;
    end else if (!activo) begin
      if (arranque) begin
        periodo   = ((int'(valor_carga) > MODULO - 1) ? MODULO - 1 : int'(valor_carga)) + 1;
        restantes = periodo;
        activo    = 1;
      end
    end else if (parar) begin
      activo   = 0;
      mostrada = restantes - 1;
    end else if (enable) begin
      restantes = restantes - 1;
      if (restantes == 0) begin
        pulso = 1;
`ifdef AUTORRECARGA_EN
        restantes = periodo;
`else
        activo   = 0;
        mostrada = 0;
        restantes = 1;
`endif
      end
    end
    e.cuenta     = W'(activo ? restantes - 1 : mostrada);
    e.ocupado    = activo;
    e.fin_cuenta = pulso;
    esperado_q.push_back(e);
  end

  // Monitor: outputs are valid every cycle, sampled 1 time unit after the edge.
  always @(posedge clock) begin
    salida_t e;
    #1;
    if (esperado_q.size() > 0) begin
      e = esperado_q.pop_front();
      total++;
      if ({cuenta, ocupado, fin_cuenta} !== e) begin
        bad++;
        $display("FAIL salida t=%0t: got cuenta=%0d ocupado=%0b fin=%0b, want cuenta=%0d ocupado=%0b fin=%0b",
                 $time, cuenta, ocupado, fin_cuenta, e.cuenta, e.ocupado, e.fin_cuenta);
      end
    end
  end

  task automatic paso(input logic r, input logic a, input int unsigned v,
                      input logic e, input logic p);
    @(negedge clock);
    reset       = r;
    arranque    = a;
    valor_carga = W'(v);
    enable      = e;
    parar       = p;
  endtask

  task automatic pasos(input int unsigned n, input logic e);
    for (int unsigned i = 0; i < n; i++) paso(1, 0, 0, e, 0);
  endtask

  initial begin
    // initial reset
    paso(0, 0, 0, 0, 0);
    paso(0, 0, 0, 0, 0);
    pasos(2, 0);

    // load 3, enable held high: 3,2,1,0 then terminal pulse
    paso(1, 1, 3, 1, 0);
    pasos(6, 1);

    // load 0, five idle cycles, single enable tick
    paso(1, 1, 0, 0, 0);
    pasos(5, 0);
    pasos(1, 1);
    pasos(3, 0);

    // load 9, count to 0, then parar together with enable
    paso(1, 1, 9, 0, 0);
    pasos(9, 1);
    paso(1, 0, 0, 1, 1);
    pasos(3, 0);

    // load 5, arranque during count ignored, run to terminal
    paso(1, 1, 5, 0, 0);
    paso(1, 1, 12, 1, 0);
    paso(1, 1, 12, 1, 0);
    pasos(5, 1);
    paso(1, 0, 0, 0, 1);
    pasos(1, 0);
    // saturated load: 15 -> MODULO-1
    paso(1, 1, 15, 0, 0);
    pasos(2, 1);
    paso(1, 0, 0, 0, 1);
    pasos(1, 0);

    // reset mid-count at cuenta=7
    paso(1, 1, 9, 0, 0);
    pasos(2, 1);
    paso(0, 0, 0, 1, 0);
    paso(0, 0, 0, 1, 0);
    pasos(2, 1);

    // load 2, nine enables (periodic with auto-reload, one-shot otherwise)
    paso(1, 1, 2, 0, 0);
    pasos(9, 1);
    paso(1, 0, 0, 0, 1);
    pasos(2, 0);

    // randomized traffic
    for (int unsigned i = 0; i < 600; i++) begin
      paso(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) == 0),
           $urandom_range(0, (1 << W) - 1), $urandom_range(0, 1) == 1,
           ($urandom_range(0, 15) == 0));
    end
    pasos(3, 0);

    @(posedge clock);
    #2;
    if (total < 12) begin
      bad++;
      $display("FAIL cobertura: got %0d comparisons, want at least 12", total);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
